// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side drain: word width, drain FSM states, skid depth.
// Pure declarations; no timing or flow-control behaviour of its own.
// Imported by fifo_rd_drain and fifo_rd_skid.
package fifo_pkg;
   localparam int DATA_WIDTH = 8;
   localparam int SKID_DEPTH = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      GAP  = 2'd2
   } rd_state_t;
endpackage

// File: rtl/fifo_rd_skid.sv
// 3-entry in-order skid buffer: push/pop with occupancy count, head word always visible.
// Latency: a pushed word is at the head the cycle after the push edge when the buffer was empty.
// Backpressure: pop only while occupied; a push into a full buffer is dropped unless a pop frees a slot.
module fifo_rd_skid
   import fifo_pkg::*;
#(
   parameter int W = DATA_WIDTH
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_dat,
   input  logic         pop,
   output logic [W-1:0] head_dat,
   output logic [1:0]   occ
);
   logic [W-1:0] mem [SKID_DEPTH];
   logic [1:0]   wr_ptr;
   logic [1:0]   rd_ptr;
   logic         do_push;
   logic         do_pop;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'(SKID_DEPTH - 1)) ? 2'd0 : p + 2'd1;
   endfunction

   assign do_pop   = pop && (occ != 2'd0);
   assign do_push  = push && ((occ != 2'(SKID_DEPTH)) || do_pop);
   assign head_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         occ    <= 2'd0;
         for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
         if (do_push && !do_pop)      occ <= occ + 2'd1;
         else if (!do_push && do_pop) occ <= occ - 2'd1;
      end
   end
endmodule

// File: rtl/fifo_rd_drain.sv
// Burst reader for the async FIFO read port feeding a valid/ready stream (stats: FIFO_RD_DRAIN_STATS_EN).
// Latency: rd_en in cycle N -> word captured end of N+1 -> out_valid in N+2; one word/cycle sustained.
// Backpressure: reads are credited against the 3-entry skid (occ + inflight < 3); out_ready never reaches rd_en combinationally.
module fifo_rd_drain
   import fifo_pkg::*;
#(
   parameter int BURST_LEN   = 16,
   parameter int IDLE_CYCLES = 2
)(
   input  logic                  clk_rd,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  empty,
   input  logic [DATA_WIDTH-1:0] data_out,
   output logic                  rd_en,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  burst_done
`ifdef FIFO_RD_DRAIN_STATS_EN
   ,
   output logic [31:0]           words_read,
   output logic [31:0]           stall_cycles
`endif
);
   localparam int CW = $clog2(BURST_LEN + 1);
   localparam int GW = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
   localparam logic [CW-1:0] LAST_RD  = CW'(BURST_LEN - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);

   rd_state_t     state, state_nxt;
   logic [CW-1:0] burst_cnt, burst_cnt_nxt;
   logic [GW-1:0] gap_cnt, gap_cnt_nxt;
   logic          inflight;
   logic [1:0]    occ;
   logic          credit_ok;
   logic          last_rd;

   // The in-flight read already owns a skid slot, so it counts against the credit.
   assign credit_ok  = ({1'b0, occ} + {2'b00, inflight}) < 3'(SKID_DEPTH);
   assign rd_en      = (state == READ) && !empty && credit_ok;
   assign last_rd    = rd_en && (burst_cnt == LAST_RD);
   assign burst_done = last_rd;
   assign out_valid  = (occ != 2'd0);

   always_comb begin
      state_nxt     = state;
      burst_cnt_nxt = burst_cnt;
      gap_cnt_nxt   = gap_cnt;
      case (state)
         IDLE: begin
            if (en) begin
               state_nxt     = READ;
               burst_cnt_nxt = '0;
            end
         end
         READ: begin
            if (rd_en) begin
               burst_cnt_nxt = burst_cnt + CW'(1);
               if (last_rd) begin
                  if (IDLE_CYCLES == 0) begin
                     if (en) begin
                        state_nxt     = READ;
                        burst_cnt_nxt = '0;
                     end else begin
                        state_nxt = IDLE;
                     end
                  end else begin
                     state_nxt   = GAP;
                     gap_cnt_nxt = '0;
                  end
               end
            end
         end
         GAP: begin
            if (gap_cnt == GAP_LAST) begin
               if (en) begin
                  state_nxt     = READ;
                  burst_cnt_nxt = '0;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               gap_cnt_nxt = gap_cnt + GW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_rd) begin
      if (rst) begin
         state     <= IDLE;
         burst_cnt <= '0;
         gap_cnt   <= '0;
         inflight  <= 1'b0;
      end else begin
         state     <= state_nxt;
         burst_cnt <= burst_cnt_nxt;
         gap_cnt   <= gap_cnt_nxt;
         inflight  <= rd_en;
      end
   end

   fifo_rd_skid #(.W(DATA_WIDTH)) u_skid (
      .clk      (clk_rd),
      .rst      (rst),
      .push     (inflight),
      .push_dat (data_out),
      .pop      (out_valid && out_ready),
      .head_dat (out_data),
      .occ      (occ)
   );

`ifdef FIFO_RD_DRAIN_STATS_EN
   always_ff @(posedge clk_rd) begin
      if (rst) begin
         words_read   <= 32'd0;
         stall_cycles <= 32'd0;
      end else begin
         if (inflight) words_read <= words_read + 32'd1;
         if ((state == READ) && (empty || !credit_ok) && (stall_cycles != 32'hFFFF_FFFF))
            stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: FIFO and stream partner models plus a word-order scoreboard.
// u0 uses BURST_LEN=4/IDLE_CYCLES=2, u1 uses BURST_LEN=4/IDLE_CYCLES=0.
module tb_fifo_rd_drain;
   import fifo_pkg::*;

   localparam int BL    = 4;
   localparam int IDLE0 = 2;

   logic clk_rd = 1'b0;
   always #5 clk_rd = ~clk_rd;

   logic rst;
   logic en0, empty0, rd_en0, out_valid0, out_ready0, burst_done0;
   logic en1, empty1, rd_en1, out_valid1, out_ready1, burst_done1;
   logic [DATA_WIDTH-1:0] data_out0, out_data0, data_out1, out_data1;
`ifdef FIFO_RD_DRAIN_STATS_EN
   logic [31:0] words_read0, stall_cycles0, words_read1, stall_cycles1;
`endif

   fifo_rd_drain #(.BURST_LEN(BL), .IDLE_CYCLES(IDLE0)) u0 (
      .clk_rd(clk_rd), .rst(rst), .en(en0), .empty(empty0), .data_out(data_out0),
      .rd_en(rd_en0), .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready0),
      .burst_done(burst_done0)
`ifdef FIFO_RD_DRAIN_STATS_EN
      , .words_read(words_read0), .stall_cycles(stall_cycles0)
`endif
   );

   fifo_rd_drain #(.BURST_LEN(BL), .IDLE_CYCLES(0)) u1 (
      .clk_rd(clk_rd), .rst(rst), .en(en1), .empty(empty1), .data_out(data_out1),
      .rd_en(rd_en1), .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
      .burst_done(burst_done1)
`ifdef FIFO_RD_DRAIN_STATS_EN
      , .words_read(words_read1), .stall_cycles(stall_cycles1)
`endif
   );

   // FIFO models: contents, forced-empty control, and words handed to each DUT (expected output order).
   logic [DATA_WIDTH-1:0] q0[$], q1[$], sb0[$], sb1[$];
   logic hold0, hold1;
   logic rs0 = 1'b0, rs1 = 1'b0;

   always begin
      @(posedge clk_rd);
      #1;
      if (rs0 && q0.size() != 0) begin
         data_out0 = q0.pop_front();
         sb0.push_back(data_out0);
      end
      if (rs1 && q1.size() != 0) begin
         data_out1 = q1.pop_front();
         sb1.push_back(data_out1);
      end
      #2;
      empty0 = hold0 || (q0.size() == 0);
      empty1 = hold1 || (q1.size() == 0);
      @(negedge clk_rd);
      rs0 = rd_en0;
      rs1 = rd_en1;
   end

   int n_cmp = 0;
   int n_err = 0;
   int rd0, pop0, bd0, gap0, rd1, pop1, bd1;
   logic pv0, pr0;
   logic [DATA_WIDTH-1:0] pd0;
   logic [10:0] rdhist0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: sample and check at the falling edge, return 2 units after the rising edge.
   task automatic cyc();
      logic [DATA_WIDTH-1:0] e;
      @(negedge clk_rd);
      if (!rst) begin
         chk("rd_while_empty0", 32'(rd_en0 & empty0), 32'd0);
         chk("burst_done0", 32'(burst_done0), 32'(rd_en0 && (rd0 % BL == BL - 1)));
         if (gap0 > 0) begin
            chk("gap_no_read0", 32'(rd_en0), 32'd0);
            gap0--;
         end
         if (burst_done0) begin
            gap0 = IDLE0;
            bd0++;
         end
         if (pv0 && !pr0) begin
            chk("stall_valid0", 32'(out_valid0), 32'd1);
            chk("stall_data0", 32'(out_data0), 32'(pd0));
         end
         rd0 += int'(rd_en0);
         chk("credit0", 32'(rd0 - pop0 <= 3), 32'd1);
         if (out_valid0 && out_ready0) begin
            if (sb0.size() != 0) e = sb0.pop_front();
            else e = 'x;
            chk("out_data0", 32'(out_data0), 32'(e));
            pop0++;
         end
         pv0 = out_valid0; pr0 = out_ready0; pd0 = out_data0;
         rdhist0 = {rdhist0[9:0], rd_en0};

         chk("rd_while_empty1", 32'(rd_en1 & empty1), 32'd0);
         chk("burst_done1", 32'(burst_done1), 32'(rd_en1 && (rd1 % BL == BL - 1)));
         if (burst_done1) bd1++;
         rd1 += int'(rd_en1);
         if (out_valid1 && out_ready1) begin
            if (sb1.size() != 0) e = sb1.pop_front();
            else e = 'x;
            chk("out_data1", 32'(out_data1), 32'(e));
            pop1++;
         end
      end
      @(posedge clk_rd);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1; en0 = 1'b0; en1 = 1'b0; hold0 = 1'b0; hold1 = 1'b0;
      out_ready0 = 1'b1; out_ready1 = 1'b1;
      cyc();
      cyc();
      @(negedge clk_rd);
      chk("rst_rd_en", 32'(rd_en0), 32'd0);
      chk("rst_out_valid", 32'(out_valid0), 32'd0);
      chk("rst_out_data", 32'(out_data0), 32'd0);
      chk("rst_burst_done", 32'(burst_done0), 32'd0);
      @(posedge clk_rd);
      #2;
      q0.delete(); q1.delete(); sb0.delete(); sb1.delete();
      rd0 = 0; pop0 = 0; bd0 = 0; gap0 = 0; rd1 = 0; pop1 = 0; bd1 = 0;
      pv0 = 1'b0; pr0 = 1'b1; pd0 = '0; rdhist0 = '0;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; hold0 = 1'b1; hold1 = 1'b1;
      en0 = 1'b0; en1 = 1'b0; out_ready0 = 1'b1; out_ready1 = 1'b1;

      // Two bursts of 4 separated by a 2-cycle gap, words 0x01..0x08 in order.
      do_reset();
      for (int i = 1; i <= 8; i++) q0.push_back(8'(i));
      en0 = 1'b1;
      repeat (11) cyc();
      chk("rd_en_pattern", 32'(rdhist0), 32'b011110011_11);
      repeat (6) cyc();
      chk("bursts_done_2", 32'(bd0), 32'd2);
      chk("words_out_8", 32'(pop0), 32'd8);

      // FIFO runs dry after 2 reads; en drops mid-burst; burst finishes once data returns.
      do_reset();
      q0.push_back(8'($urandom)); q0.push_back(8'($urandom));
      en0 = 1'b1;
      cyc(); cyc();
      en0 = 1'b0;
      repeat (6) cyc();
      chk("stalled_reads", 32'(rd0), 32'd2);
      chk("stalled_no_done", 32'(bd0), 32'd0);
      for (int i = 0; i < 6; i++) q0.push_back(8'($urandom));
      repeat (10) cyc();
      chk("resumed_reads", 32'(rd0), 32'd4);
      chk("resumed_done", 32'(bd0), 32'd1);
      chk("resumed_out", 32'(pop0), 32'd4);

      // Downstream stalled for 10 cycles: 3 reads, then 0x01..0x03 drain back to back.
      do_reset();
      out_ready0 = 1'b0;
      for (int i = 1; i <= 8; i++) q0.push_back(8'(i));
      en0 = 1'b1;
      repeat (10) cyc();
      chk("bp_reads", 32'(rd0), 32'd3);
      chk("bp_head", 32'(out_data0), 32'h01);
      out_ready0 = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         chk("bp_drain_valid", 32'(out_valid0), 32'd1);
         chk("bp_drain_data", 32'(out_data0), 32'(i));
         cyc();
      end

      // Reset with 2 words buffered and one read in flight.
      do_reset();
      out_ready0 = 1'b0;
      for (int i = 0; i < 8; i++) q0.push_back(8'($urandom));
      en0 = 1'b1;
      repeat (4) cyc();
      chk("pre_rst_valid", 32'(out_valid0), 32'd1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      @(negedge clk_rd);
      chk("mid_rst_valid", 32'(out_valid0), 32'd0);
      chk("mid_rst_rd_en", 32'(rd_en0), 32'd0);
      chk("mid_rst_state", 32'(u0.state), 32'(IDLE));

      // IDLE_CYCLES=0: reads and outputs run back to back across burst boundaries.
      do_reset();
      for (int i = 0; i < 24; i++) q1.push_back(8'($urandom));
      en1 = 1'b1;
      repeat (25) cyc();
      chk("cont_reads", 32'(rd1), 32'd24);
      chk("cont_out_mid", 32'(pop1), 32'd22);
      repeat (2) cyc();
      chk("cont_out_all", 32'(pop1), 32'd24);
      chk("cont_bursts", 32'(bd1), 32'd6);

`ifdef FIFO_RD_DRAIN_STATS_EN
      // 5 empty cycles in READ followed by two full bursts of 4.
      do_reset();
      for (int i = 0; i < 8; i++) q0.push_back(8'($urandom));
      hold0 = 1'b1;
      en0 = 1'b1;
      repeat (6) cyc();
      hold0 = 1'b0;
      repeat (6) cyc();
      en0 = 1'b0;
      repeat (20) cyc();
      chk("stats_words", words_read0, 32'd8);
      chk("stats_stalls", stall_cycles0, 32'd5);
`endif

      // Random traffic, empty gaps, en toggling and backpressure on both instances.
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         out_ready0 = ($urandom_range(0, 3) != 0);
         out_ready1 = ($urandom_range(0, 3) != 0);
         hold0 = ($urandom_range(0, 7) == 0);
         hold1 = ($urandom_range(0, 7) == 0);
         en0 = ($urandom_range(0, 15) != 0);
         en1 = ($urandom_range(0, 15) != 0);
         if ($urandom_range(0, 2) != 0 && q0.size() < 20) q0.push_back(8'($urandom));
         if ($urandom_range(0, 2) != 0 && q1.size() < 20) q1.push_back(8'($urandom));
         cyc();
      end
      out_ready0 = 1'b1; out_ready1 = 1'b1; hold0 = 1'b0; hold1 = 1'b0; en0 = 1'b1; en1 = 1'b1;
      for (int c = 0; c < 300; c++) begin
         if (q0.size() == 0 && sb0.size() == 0 && q1.size() == 0 && sb1.size() == 0 && !out_valid0 && !out_valid1)
            break;
         cyc();
      end
      chk("drain0_left", 32'(q0.size() + sb0.size()), 32'd0);
      chk("drain1_left", 32'(q1.size() + sb1.size()), 32'd0);
      chk("drain_out_eq_rd0", 32'(pop0), 32'(rd0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
